rtype_exec_ctrl: RTL
====================

# rtype_exec_ctrl

Multi-cycle sequencer for the RV64 R-type integer path. It accepts one 32-bit instruction through a valid/ready handshake and decodes opcode, fun3 and fun7 into a one-hot operation select. It then reads two operands from an internal 32-entry register file, executes, and writes back. It sits between the instruction source and the decode/ALU logic, and owns the register file plus all sequencing, legality checks and writeback control.

## Interface
Parameters:
- XLEN, 64, datapath and register width; only 64 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  block can accept; high only in IDLE.
- instruction  in  32  instruction word; sampled on the handshake edge.
- ld_en  in  1  register-file preload write strobe.
- ld_addr  in  5  preload address.
- ld_data  in  XLEN  preload data.
- dbg_addr  in  5  debug read address.
- dbg_data  out  XLEN  combinational read of register dbg_addr; x0 always reads 0.
- op_onehot  out  15  latched operation select.
  - Bits 0-9: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - Bits 10-14: addw, subw, sllw, srlw, sraw.
- done  out  1  one-cycle pulse in the WB cycle.
- illegal  out  1  one-cycle pulse for an unsupported encoding.
- wb_addr  out  5  rd of the completing instruction.
- wb_data  out  XLEN  result of the completing instruction.

## Operation
- States: IDLE, DECODE, READ, EXEC, WB, ERR.
- IDLE:
  - in_ready=1.
  - When in_valid=1, latch the instruction and go to DECODE.
- DECODE:
  - opcode 0110011 maps to:
    - fun3 000 with fun7 0000000 → add; with fun7 0100000 → sub.
    - fun3 101 with fun7 0000000 → srl; with fun7 0100000 → sra.
    - fun3 001/010/011/100/110/111 with fun7 0000000 → sll/slt/sltu/xor/or/and.
  - opcode 0111011 maps to:
    - fun3 000 with fun7 0000000/0100000 → addw/subw.
    - fun3 001 with fun7 0000000 → sllw.
    - fun3 101 with fun7 0000000/0100000 → srlw/sraw.
  - A legal encoding sets op_onehot and goes to READ.
  - Any other encoding, including fun7 0000001 (M extension), goes to ERR with op_onehot=0.
- READ: latch the rs1 and rs2 register values. x0 reads 0.
- EXEC: compute and latch the result into wb_data.
  - Shift amount is rs2[5:0]; for W operations it is rs2[4:0].
  - slt compares signed; sltu compares unsigned; both produce 0 or 1.
  - W operations work on the low 32 bits and sign-extend bit 31 to XLEN.
  - add/sub wrap modulo 2^XLEN; no overflow flag.
- WB:
  - done=1; wb_addr=rd.
  - Write the register file unless rd=0, so x0 is never written.
  - Next state IDLE.
- ERR: illegal=1 for one cycle, no register write, next state IDLE.
- Preload:
  - ld_en is honored only while in IDLE and is ignored in all other states.
  - A write to x0 is discarded.
  - If a preload and a handshake occur on the same edge, both take effect; the accepted instruction reads the new value in READ.
- Reset:
  - All registers clear to 0; state goes to IDLE.
  - Reset during any state aborts the instruction with no writeback and no done/illegal pulse.

## Timing
- Handshake edge is cycle k.
- DECODE at k+1, READ at k+2, EXEC at k+3, WB at k+4 (done high), IDLE at k+5 (in_ready high).
- Throughput is one instruction per 5 cycles.
- The register write commits on the edge ending k+4. dbg_data shows it from k+5.
- For an illegal instruction, ERR is at k+2 (illegal high) and IDLE at k+3.
- wb_addr, wb_data and op_onehot hold their values until the next instruction overwrites them.
- During and immediately after reset:
  - in_ready=0 while rst=1.
  - done, illegal, op_onehot, wb_addr and wb_data are all 0.
  - All registers read 0.

## Test plan
- Preload x10=5, x11=3. Send 0x00B50C33 (add x24,x10,x11).
  - done at k+4 with wb_addr=24 and wb_data=8.
  - op_onehot bit0 set.
  - dbg x24=8 at k+5.
- Back-to-back instructions, with in_valid held high throughout:
  - 0x40B50C33 (sub) → 2.
  - 0x00B51C33 (sll) → 40.
  - 0x00B52C33 (slt) with x10=-1 → 1.
  - Each is accepted exactly 5 cycles apart.
- Preload x10=0x0000000080000000, x11=4. Send 0x40B55C3B (sraw x24).
  - wb_data=0xFFFFFFFFF8000000.
  - op_onehot bit14 set.
- Send 0x02B50C33 (mul encoding).
  - illegal pulse at k+2; no done.
  - x24 unchanged; in_ready at k+3.
- Send 0x00B50033 (rd=x0).
  - done at k+4 with wb_data=8.
  - dbg x0 stays 0.
  - ld_en to x5 during EXEC is ignored; x5 unchanged.
- Assert rst during EXEC for one cycle.
  - No done; all outputs 0.
  - All registers read 0.
  - in_ready=1 on the cycle after rst deasserts.

Source files
------------

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle RV64 R-type sequencer: accepts one instruction, decodes it,
// reads two operands from its own register file, executes and writes back.
//
// state  | meaning
// IDLE   | in_ready high; preload writes honored; waiting for an instruction
// DECODE | classify the latched instruction into op_onehot or flag it illegal
// READ   | latch rs1/rs2 operand values (x0 reads 0)
// EXEC   | compute the result into wb_data and present rd on wb_addr
// WB     | done pulse; commit the result to rd unless rd is x0
// ERR    | illegal pulse; no register write
module rtype_exec_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic            ld_en,
  input  logic [4:0]      ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [14:0]     op_onehot,
  output logic            done,
  output logic            illegal,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_OP32 = 7'b0111011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLL  = 2;
  localparam int OP_SLT  = 3;
  localparam int OP_SLTU = 4;
  localparam int OP_XOR  = 5;
  localparam int OP_SRL  = 6;
  localparam int OP_SRA  = 7;
  localparam int OP_OR   = 8;
  localparam int OP_AND  = 9;
  localparam int OP_ADDW = 10;
  localparam int OP_SUBW = 11;
  localparam int OP_SLLW = 12;
  localparam int OP_SRLW = 13;
  localparam int OP_SRAW = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  state_t          state;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [14:0]     dec_onehot;
  logic [XLEN-1:0] exec_result;
  logic [31:0]     word_result;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] fun3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] fun7;
  logic [5:0] shamt;
  logic [4:0] shamt_w;

  assign opcode  = instr_q[6:0];
  assign rd      = instr_q[11:7];
  assign fun3    = instr_q[14:12];
  assign rs1     = instr_q[19:15];
  assign rs2     = instr_q[24:20];
  assign fun7    = instr_q[31:25];
  assign shamt   = rs2_val[5:0];
  assign shamt_w = rs2_val[4:0];

  assign in_ready = (state == S_IDLE) && !rst;
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

  // Anything not matched here, including the M-extension fun7, stays all-zero.
  always_comb begin
    dec_onehot = '0;
    if (opcode == OPC_OP && fun7 == F7_BASE) begin
      case (fun3)
        3'b000:  dec_onehot[OP_ADD]  = 1'b1;
        3'b001:  dec_onehot[OP_SLL]  = 1'b1;
        3'b010:  dec_onehot[OP_SLT]  = 1'b1;
        3'b011:  dec_onehot[OP_SLTU] = 1'b1;
        3'b100:  dec_onehot[OP_XOR]  = 1'b1;
        3'b101:  dec_onehot[OP_SRL]  = 1'b1;
        3'b110:  dec_onehot[OP_OR]   = 1'b1;
        default: dec_onehot[OP_AND]  = 1'b1;
      endcase
    end else if (opcode == OPC_OP && fun7 == F7_ALT) begin
      case (fun3)
        3'b000:  dec_onehot[OP_SUB] = 1'b1;
        3'b101:  dec_onehot[OP_SRA] = 1'b1;
        default: dec_onehot = '0;
      endcase
    end else if (opcode == OPC_OP32 && fun7 == F7_BASE) begin
      case (fun3)
        3'b000:  dec_onehot[OP_ADDW] = 1'b1;
        3'b001:  dec_onehot[OP_SLLW] = 1'b1;
        3'b101:  dec_onehot[OP_SRLW] = 1'b1;
        default: dec_onehot = '0;
      endcase
    end else if (opcode == OPC_OP32 && fun7 == F7_ALT) begin
      case (fun3)
        3'b000:  dec_onehot[OP_SUBW] = 1'b1;
        3'b101:  dec_onehot[OP_SRAW] = 1'b1;
        default: dec_onehot = '0;
      endcase
    end
  end

  always_comb begin
    word_result = '0;
    exec_result = '0;
    case (1'b1)
      op_onehot[OP_ADD]:  exec_result = rs1_val + rs2_val;
      op_onehot[OP_SUB]:  exec_result = rs1_val - rs2_val;
      op_onehot[OP_SLL]:  exec_result = rs1_val << shamt;
      op_onehot[OP_SLT]:  exec_result = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(rs2_val)};
      op_onehot[OP_SLTU]: exec_result = {{(XLEN-1){1'b0}}, rs1_val < rs2_val};
      op_onehot[OP_XOR]:  exec_result = rs1_val ^ rs2_val;
      op_onehot[OP_SRL]:  exec_result = rs1_val >> shamt;
      op_onehot[OP_SRA]:  exec_result = XLEN'($signed(rs1_val) >>> shamt);
      op_onehot[OP_OR]:   exec_result = rs1_val | rs2_val;
      op_onehot[OP_AND]:  exec_result = rs1_val & rs2_val;
      op_onehot[OP_ADDW]: word_result = rs1_val[31:0] + rs2_val[31:0];
      op_onehot[OP_SUBW]: word_result = rs1_val[31:0] - rs2_val[31:0];
      op_onehot[OP_SLLW]: word_result = rs1_val[31:0] << shamt_w;
      op_onehot[OP_SRLW]: word_result = rs1_val[31:0] >> shamt_w;
      op_onehot[OP_SRAW]: word_result = 32'($signed(rs1_val[31:0]) >>> shamt_w);
      default:            exec_result = '0;
    endcase
    // W operations produce a 32-bit result sign-extended to the full width.
    if (|op_onehot[OP_SRAW:OP_ADDW]) begin
      exec_result = {{(XLEN-32){word_result[31]}}, word_result};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      instr_q   <= '0;
      rs1_val   <= '0;
      rs2_val   <= '0;
      op_onehot <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_en && ld_addr != 5'd0) begin
            regs[ld_addr] <= ld_data;
          end
          if (in_valid) begin
            instr_q <= instruction;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_onehot <= dec_onehot;
          if (dec_onehot != '0) begin
            state <= S_READ;
          end else begin
            illegal <= 1'b1;
            state   <= S_ERR;
          end
        end
        S_READ: begin
          rs1_val <= (rs1 == 5'd0) ? '0 : regs[rs1];
          rs2_val <= (rs2 == 5'd0) ? '0 : regs[rs2];
          state   <= S_EXEC;
        end
        S_EXEC: begin
          wb_data <= exec_result;
          wb_addr <= rd;
          done    <= 1'b1;
          state   <= S_WB;
        end
        S_WB: begin
          if (rd != 5'd0) begin
            regs[rd] <= wb_data;
          end
          state <= S_IDLE;
        end
        S_ERR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
